wb_burst_ram: RTL and testbench

Wishbone B3 slave memory with registered-feedback burst support; the downstream consumer of the randomized Wishbone burst master transactor. Accepts classic, constant-address and incrementing (linear, wrap-4/8/16) bursts with byte selects and programmable initial wait states. Predicts each burst address internally, pre-fetches read data, flags out-of-range beats with err and flags master address-sequence violations on a sticky output.

---
 rtl/wb_burst_ram.sv | 180 ++++++++++++++++++
 tb/tb_wb_burst_ram.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_ram.sv
// Wishbone B3 registered-feedback burst slave memory: predicts burst addresses,
// pre-fetches read data, flags out-of-range beats and master address-sequence violations.
module wb_burst_ram #(
  parameter int            aw        = 32,
  parameter int            dw        = 32,
  parameter logic [aw-1:0] MEM_LOW   = '0,
  parameter int            MEM_WORDS = 1024
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic [aw-1:0]   wb_adr_i,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic [dw/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  input  logic [3:0]      wait_states_i,
  output logic [dw-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o,
  output logic            seq_err_o
);

  localparam int SW = dw / 8;
  localparam int BS = $clog2(SW);
  localparam int IW = $clog2(MEM_WORDS);
  localparam logic [aw:0] SPAN = (aw+1)'(MEM_WORDS) << BS;

  typedef enum logic [1:0] {IDLE, WAIT, CLASSIC_ACK, BURST} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [aw-1:0] adr_q;
  logic [2:0]    cti_q;
  logic [1:0]    bte_q;

  logic [dw-1:0] mem [MEM_WORDS];

  logic          resp, beat_done, wr_en, start_go, start_ok, start_burst, nxt_ok;
  logic [IW-1:0] wr_idx, start_idx, nxt_idx;
  logic [dw-1:0] byte_mask, wr_word, nxt_word;
  logic [aw-1:0] start_adr, nxt_adr;
  logic [2:0]    start_cti;

  // Offset is taken one bit wider so addresses below the window wrap to a huge value.
  function automatic logic in_range(input logic [aw-1:0] a);
    logic [aw:0] off;
    off = {1'b0, a} - {1'b0, MEM_LOW};
    return off < SPAN;
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [aw-1:0] a);
    logic [aw-1:0] off;
    off = (a - MEM_LOW) >> BS;
    return IW'(off);
  endfunction

  // Wrap bursts only let the low log2(N) word-index bits take the incremented value.
  function automatic logic [aw-1:0] next_adr(input logic [aw-1:0] a, input logic [1:0] bte);
    logic [aw-1:0] inc, mask;
    inc = a + aw'(SW);
    case (bte)
      2'b01:   mask = aw'(3) << BS;
      2'b10:   mask = aw'(7) << BS;
      2'b11:   mask = aw'(15) << BS;
      default: mask = '1;
    endcase
    return (a & ~mask) | (inc & mask);
  endfunction

  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < SW; i++) byte_mask[i*8 +: 8] = {8{wb_sel_i[i]}};
  end

  assign resp        = wb_ack_o | wb_err_o;
  assign beat_done   = wb_cyc_i & wb_stb_i & resp & ((state_q == CLASSIC_ACK) | (state_q == BURST));
  assign wr_idx      = word_idx(wb_adr_i);
  assign wr_en       = beat_done & wb_ack_o & wb_we_i & in_range(wb_adr_i);
  assign wr_word     = (mem[wr_idx] & ~byte_mask) | (wb_dat_i & byte_mask);

  assign start_adr   = (state_q == IDLE) ? wb_adr_i : adr_q;
  assign start_cti   = (state_q == IDLE) ? wb_cti_i : cti_q;
  assign start_ok    = in_range(start_adr);
  assign start_idx   = word_idx(start_adr);
  assign start_burst = (start_cti == 3'b001) || (start_cti == 3'b010);
  assign start_go    = ((state_q == IDLE) && wb_cyc_i && wb_stb_i && (wait_states_i == 4'd0)) ||
                       ((state_q == WAIT) && wb_cyc_i && (cnt_q == 4'd1));

  // A write landing on the word about to be pre-fetched is forwarded so the next beat sees it.
  assign nxt_adr     = (cti_q == 3'b001) ? adr_q : next_adr(adr_q, bte_q);
  assign nxt_ok      = in_range(nxt_adr);
  assign nxt_idx     = word_idx(nxt_adr);
  assign nxt_word    = (wr_en && (nxt_idx == wr_idx)) ? wr_word : mem[nxt_idx];

  assign wb_rty_o    = 1'b0;

  always_ff @(posedge wb_clk_i) begin
    if (wr_en) mem[wr_idx] <= wr_word;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      adr_q     <= '0;
      cti_q     <= '0;
      bte_q     <= '0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      wb_dat_o  <= '0;
      seq_err_o <= 1'b0;
    end else begin
      if (beat_done && (wb_adr_i != adr_q)) seq_err_o <= 1'b1;
      unique case (state_q)
        IDLE: begin
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          if (wb_cyc_i && wb_stb_i) begin
            adr_q   <= wb_adr_i;
            cti_q   <= wb_cti_i;
            bte_q   <= wb_bte_i;
            cnt_q   <= wait_states_i;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!wb_cyc_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        CLASSIC_ACK: begin
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          state_q  <= IDLE;
        end
        BURST: begin
          if (!wb_cyc_i) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            state_q  <= IDLE;
          end else if (!wb_stb_i) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
          end else if (resp) begin
            if (wb_cti_i == 3'b111) begin
              wb_ack_o <= 1'b0;
              wb_err_o <= 1'b0;
              state_q  <= IDLE;
            end else begin
              adr_q    <= nxt_adr;
              wb_ack_o <= nxt_ok;
              wb_err_o <= !nxt_ok;
              if (nxt_ok) wb_dat_o <= nxt_word;
            end
          end else begin
            wb_ack_o <= in_range(adr_q);
            wb_err_o <= !in_range(adr_q);
          end
        end
        default: state_q <= IDLE;
      endcase
      // First response of a cycle, reached straight from IDLE or at the end of the wait count.
      if (start_go) begin
        state_q  <= start_burst ? BURST : CLASSIC_ACK;
        cnt_q    <= '0;
        wb_ack_o <= start_ok;
        wb_err_o <= !start_ok;
        if (start_ok) wb_dat_o <= mem[start_idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_ram.sv
// Directed bench for wb_burst_ram: stimulus pushes expected beat responses into a
// scoreboard queue that a negedge monitor pops on every completed beat.
module tb_wb_burst_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr, dat, dat_o;
  logic [3:0]  sel, wait_states;
  logic        we, cyc, stb, ack, err, rty, seq;
  logic [2:0]  cti;
  logic [1:0]  bte;

  always #5 clk = ~clk;

  wb_burst_ram #(.aw(32), .dw(32), .MEM_LOW(32'h0), .MEM_WORDS(1024)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wait_states_i(wait_states), .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err),
    .wb_rty_o(rty), .seq_err_o(seq)
  );

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [31:0] dat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e, stim_e;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] v_adr[16], v_dat[16], v_exp[16];
  logic        v_err[16];
  int          lat, xw, sa, tr, waits;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // A beat completes when the slave responds while the master strobes.
  always @(negedge clk) begin
    if (rst_n && cyc && stb && (ack || err)) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_resp", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("resp_is_err", 32'(err), 32'(mon_e.err));
        if (mon_e.chk) checkOutput("rd_data", dat_o, mon_e.dat);
      end
    end
  end

  // One bus cycle of n beats from v_adr/v_dat; reports first-response latency in negedges,
  // extra wait negedges after the first beat, acks seen during a stall, and responses after the end.
  task automatic applyStimulus(input logic we_v, input logic [2:0] kind, input logic [1:0] bte_v,
                               input int n, input logic [3:0] sel_v, input logic [3:0] ws,
                               input int stall_at, input int stall_len,
                               output int first_lat, output int extra_waits,
                               output int stall_ack, output int tail_resp);
    int w;
    first_lat = 0; extra_waits = 0; stall_ack = 0; tail_resp = 0;
    for (int i = 0; i < n; i++) begin
      stim_e.err = v_err[i];
      stim_e.chk = !we_v && !v_err[i];
      stim_e.dat = v_exp[i];
      exp_q.push_back(stim_e);
    end
    @(posedge clk); #1;
    cyc = 1'b1; we = we_v; sel = sel_v; bte = bte_v; wait_states = ws;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        stb = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          if (s > 0 && ack) stall_ack++;
          @(posedge clk); #1;
        end
      end
      stb = 1'b1;
      adr = v_adr[i];
      dat = v_dat[i];
      cti = (kind == 3'b000) ? 3'b000 : ((i == n - 1) ? 3'b111 : kind);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!(ack || err) && w < 64);
      if (!(ack || err)) begin
        checkOutput("beat_timeout", w, 32'd0);
        break;
      end
      if (i == 0) first_lat = w;
      else extra_waits += w - 1;
      @(posedge clk); #1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ack || err) tail_resp++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0;
    sel = '0; cti = '0; bte = '0; wait_states = '0;
    for (int i = 0; i < 16; i++) begin
      v_adr[i] = '0; v_dat[i] = '0; v_exp[i] = '0; v_err[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_rty", 32'(rty), 32'd0);
    checkOutput("rst_dat", dat_o, 32'd0);
    checkOutput("rst_seq", 32'(seq), 32'd0);
    rst_n = 1'b1;

    // Classic write then read of word 4, no wait states: ack one cycle after stb.
    v_adr[0] = 32'h10; v_dat[0] = 32'hDEADBEEF; v_exp[0] = 32'h0;
    applyStimulus(1'b1, 3'b000, 2'b00, 1, 4'hF, 4'd0, -1, 0, lat, xw, sa, tr);
    checkOutput("cw_latency", lat, 32'd2);
    checkOutput("cw_tail", tr, 32'd0);
    v_exp[0] = 32'hDEADBEEF;
    applyStimulus(1'b0, 3'b000, 2'b00, 1, 4'hF, 4'd0, -1, 0, lat, xw, sa, tr);
    checkOutput("cr_latency", lat, 32'd2);
    checkOutput("cr_tail", tr, 32'd0);

    // Three wait states: first response on the fourth negedge after the request edge.
    applyStimulus(1'b0, 3'b000, 2'b00, 1, 4'hF, 4'd3, -1, 0, lat, xw, sa, tr);
    checkOutput("w3_latency", lat, 32'd5);
    checkOutput("w3_single_ack", tr, 32'd0);

    // Wrap-4 write from word 6 (6,7,4,5), then linear read of words 4..7.
    v_adr[0] = 32'h18; v_adr[1] = 32'h1C; v_adr[2] = 32'h10; v_adr[3] = 32'h14;
    v_dat[0] = 32'hCAFE0000; v_dat[1] = 32'hCAFE0001; v_dat[2] = 32'hCAFE0002; v_dat[3] = 32'hCAFE0003;
    applyStimulus(1'b1, 3'b010, 2'b01, 4, 4'hF, 4'd0, -1, 0, lat, xw, sa, tr);
    checkOutput("wrap_wr_consecutive", xw, 32'd0);
    v_adr[0] = 32'h10; v_adr[1] = 32'h14; v_adr[2] = 32'h18; v_adr[3] = 32'h1C;
    v_exp[0] = 32'hCAFE0002; v_exp[1] = 32'hCAFE0003; v_exp[2] = 32'hCAFE0000; v_exp[3] = 32'hCAFE0001;
    applyStimulus(1'b0, 3'b010, 2'b00, 4, 4'hF, 4'd0, -1, 0, lat, xw, sa, tr);
    checkOutput("lin_rd_consecutive", xw, 32'd0);
    checkOutput("lin_rd_tail", tr, 32'd0);
    checkOutput("seq_clean_wrap", 32'(seq), 32'd0);

    // Linear 8-beat write and read of words 8..15, master stalls 2 cycles after beat 3.
    for (int i = 0; i < 8; i++) begin
      v_adr[i] = 32'h20 + 32'(4 * i);
      v_dat[i] = 32'h0B000000 | 32'(i);
      v_exp[i] = 32'h0B000000 | 32'(i);
      v_err[i] = 1'b0;
    end
    applyStimulus(1'b1, 3'b010, 2'b00, 8, 4'hF, 4'd0, 3, 2, lat, xw, sa, tr);
    checkOutput("stall_wr_ack_low", sa, 32'd0);
    checkOutput("stall_wr_resume", xw, 32'd1);
    applyStimulus(1'b0, 3'b010, 2'b00, 8, 4'hF, 4'd1, 3, 2, lat, xw, sa, tr);
    checkOutput("stall_rd_latency", lat, 32'd3);
    checkOutput("stall_rd_ack_low", sa, 32'd0);
    checkOutput("stall_rd_resume", xw, 32'd1);
    checkOutput("seq_clean_stall", 32'(seq), 32'd0);

    // Master skips 0x28: data still follows the predicted sequence and seq_err sticks.
    v_adr[0] = 32'h20; v_adr[1] = 32'h24; v_adr[2] = 32'h2C; v_adr[3] = 32'h30;
    applyStimulus(1'b0, 3'b010, 2'b00, 4, 4'hF, 4'd0, -1, 0, lat, xw, sa, tr);
    checkOutput("seq_err_set", 32'(seq), 32'd1);
    v_adr[0] = 32'h10; v_exp[0] = 32'hCAFE0002;
    applyStimulus(1'b0, 3'b000, 2'b00, 1, 4'hF, 4'd0, -1, 0, lat, xw, sa, tr);
    checkOutput("seq_err_sticky", 32'(seq), 32'd1);

    // Out-of-range write must not alias onto word 0; then a partial byte-select write.
    v_adr[0] = 32'h0; v_dat[0] = 32'h11223344;
    applyStimulus(1'b1, 3'b000, 2'b00, 1, 4'hF, 4'd0, -1, 0, lat, xw, sa, tr);
    v_adr[0] = 32'h1000; v_dat[0] = 32'hFFFFFFFF; v_err[0] = 1'b1;
    applyStimulus(1'b1, 3'b000, 2'b00, 1, 4'hF, 4'd0, -1, 0, lat, xw, sa, tr);
    checkOutput("oor_wr_latency", lat, 32'd2);
    checkOutput("oor_wr_single_err", tr, 32'd0);
    applyStimulus(1'b0, 3'b000, 2'b00, 1, 4'hF, 4'd0, -1, 0, lat, xw, sa, tr);
    v_adr[0] = 32'h0; v_err[0] = 1'b0; v_exp[0] = 32'h11223344;
    applyStimulus(1'b0, 3'b000, 2'b00, 1, 4'hF, 4'd0, -1, 0, lat, xw, sa, tr);
    v_dat[0] = 32'hAABBCCDD;
    applyStimulus(1'b1, 3'b000, 2'b00, 1, 4'b0101, 4'd0, -1, 0, lat, xw, sa, tr);
    for (int i = 0; i < 3; i++) begin
      v_adr[i] = 32'h0; v_exp[i] = 32'h11BB33DD; v_err[i] = 1'b0;
    end
    applyStimulus(1'b0, 3'b001, 2'b00, 3, 4'hF, 4'd0, -1, 0, lat, xw, sa, tr);
    checkOutput("const_rd_consecutive", xw, 32'd0);

    // Reset asserted while beat 1 of a linear read is being acknowledged.
    stim_e.err = 1'b0; stim_e.chk = 1'b1; stim_e.dat = 32'h0B000000;
    exp_q.push_back(stim_e);
    stim_e.dat = 32'h0B000001;
    exp_q.push_back(stim_e);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; cti = 3'b010; bte = 2'b00;
    wait_states = 4'd0; adr = 32'h20;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!ack && waits < 64);
    checkOutput("mid_first_ack", 32'(ack), 32'd1);
    @(posedge clk); #1;
    adr = 32'h24;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ack", 32'(ack), 32'd0);
    checkOutput("mid_rst_err", 32'(err), 32'd0);
    checkOutput("mid_rst_dat", dat_o, 32'd0);
    checkOutput("mid_rst_seq", 32'(seq), 32'd0);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000; adr = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("mid_sb_drained", exp_q.size(), 32'd0);
    v_adr[0] = 32'h24; v_exp[0] = 32'h0B000001; v_err[0] = 1'b0;
    applyStimulus(1'b0, 3'b000, 2'b00, 1, 4'hF, 4'd0, -1, 0, lat, xw, sa, tr);
    checkOutput("post_rst_latency", lat, 32'd2);

    checkOutput("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
